// File: rtl/mem_arb_2to1.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_2to1
// Brief    : Round-robin 2:1 arbiter (imem/dmem) onto one in-order memory
//            port, with a tag FIFO steering responses back to their owner.
//            Optional perf counters are built when MEM_ARB_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_2to1 #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        imemreq_val,
  output logic        imemreq_rdy,
  input  logic [31:0] imemreq_addr,
  output logic        imemresp_val,
  output logic [31:0] imemresp_data,

  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic        dmemresp_val,
  output logic [31:0] dmemresp_data,

  output logic        memreq_val,
  input  logic        memreq_rdy,
  output logic        memreq_type,
  output logic [31:0] memreq_addr,
  output logic [31:0] memreq_wdata,
  input  logic        memresp_val,
  input  logic [31:0] memresp_data,

  output logic [31:0] perf_imem_grants,
  output logic [31:0] perf_dmem_grants,
  output logic [31:0] perf_conflicts
);

  localparam int                 c_ptr_w   = $clog2(MAX_INFLIGHT);
  localparam int                 c_cnt_w   = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(MAX_INFLIGHT);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  logic                    prio_q,  prio_d;
  logic [c_cnt_w-1:0]      count_q, count_d;
  logic [c_ptr_w-1:0]      head_q,  head_d;
  logic [c_ptr_w-1:0]      tail_q,  tail_d;
  logic [MAX_INFLIGHT-1:0] tags_q,  tags_d;

  logic w_full;
  logic w_both;
  logic w_any;
  logic w_sel_dmem;
  logic w_fire;
  logic w_pop;
  logic w_head_tag;

  assign w_full     = (count_q == c_full);
  assign w_both     = imemreq_val & dmemreq_val;
  assign w_any      = imemreq_val | dmemreq_val;
  assign w_sel_dmem = w_both ? prio_q : dmemreq_val;

  // Handshake outputs are gated by rst so nothing can fire while held in reset.
  assign memreq_val  = w_any & ~w_full & ~rst;
  assign w_fire      = memreq_val & memreq_rdy;
  assign imemreq_rdy = w_fire & ~w_sel_dmem;
  assign dmemreq_rdy = w_fire &  w_sel_dmem;

  assign memreq_type  = w_sel_dmem ? dmemreq_type  : 1'b0;
  assign memreq_addr  = w_sel_dmem ? dmemreq_addr  : imemreq_addr;
  assign memreq_wdata = w_sel_dmem ? dmemreq_wdata : 32'd0;

  // Responses with nothing outstanding are dropped without touching state.
  assign w_pop      = memresp_val & (count_q != '0) & ~rst;
  assign w_head_tag = tags_q[head_q];

  assign imemresp_val  = w_pop & ~w_head_tag;
  assign dmemresp_val  = w_pop &  w_head_tag;
  assign imemresp_data = memresp_data;
  assign dmemresp_data = memresp_data;

  always_comb begin
    prio_d  = prio_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    tags_d  = tags_q;
    if (w_fire) begin
      tags_d[tail_q] = w_sel_dmem;
      tail_d         = tail_q + c_ptr_one;
      if (w_both) begin
        prio_d = ~w_sel_dmem;
      end
    end
    if (w_pop) begin
      head_d = head_q + c_ptr_one;
    end
    case ({w_fire, w_pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q  <= 1'b0;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      tags_q  <= '0;
    end else begin
      prio_q  <= prio_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      tags_q  <= tags_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] imem_grants_q;
  logic [31:0] dmem_grants_q;
  logic [31:0] conflicts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_grants_q <= 32'd0;
      dmem_grants_q <= 32'd0;
      conflicts_q   <= 32'd0;
    end else begin
      if (imemreq_rdy) imem_grants_q <= imem_grants_q + 32'd1;
      if (dmemreq_rdy) dmem_grants_q <= dmem_grants_q + 32'd1;
      if (w_both)      conflicts_q   <= conflicts_q + 32'd1;
    end
  end

  assign perf_imem_grants = imem_grants_q;
  assign perf_dmem_grants = dmem_grants_q;
  assign perf_conflicts   = conflicts_q;
`else
  assign perf_imem_grants = 32'd0;
  assign perf_dmem_grants = 32'd0;
  assign perf_conflicts   = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arb_2to1.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arb_2to1
// Brief    : Directed and randomized bench for mem_arb_2to1 against a
//            queue-based owner model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arb_2to1;

  localparam int MAXI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemreq_val, imemreq_rdy, imemresp_val;
  logic [31:0] imemreq_addr, imemresp_data;
  logic        dmemreq_val, dmemreq_rdy, dmemreq_type, dmemresp_val;
  logic [31:0] dmemreq_addr, dmemreq_wdata, dmemresp_data;
  logic        memreq_val, memreq_rdy, memreq_type, memresp_val;
  logic [31:0] memreq_addr, memreq_wdata, memresp_data;
  logic [31:0] perf_imem_grants, perf_dmem_grants, perf_conflicts;

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  mem_arb_2to1 #(.MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_addr(imemreq_addr),
    .imemresp_val(imemresp_val), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_type(dmemreq_type),
    .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
    .dmemresp_val(dmemresp_val), .dmemresp_data(dmemresp_data),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
    .memreq_addr(memreq_addr), .memreq_wdata(memreq_wdata),
    .memresp_val(memresp_val), .memresp_data(memresp_data),
    .perf_imem_grants(perf_imem_grants), .perf_dmem_grants(perf_dmem_grants),
    .perf_conflicts(perf_conflicts)
  );

  // Reference model: owner queue of outstanding requests plus tie-break favour.
  bit          m_fav;
  bit          m_owner[$];
  int unsigned m_pi, m_pd, m_pc;
  logic        e_mval, e_irdy, e_drdy, e_ival, e_dval, e_seld, e_type;
  logic [31:0] e_addr, e_wdata;

  task automatic model_clear();
    m_owner.delete();
    m_fav = 1'b0;
    m_pi = 0; m_pd = 0; m_pc = 0;
  endtask

  task automatic model_eval();
    bit full;
    full   = (m_owner.size() == MAXI);
    e_seld = (imemreq_val && dmemreq_val) ? m_fav : dmemreq_val;
    e_mval = (imemreq_val || dmemreq_val) && !full;
    e_irdy = e_mval && memreq_rdy && !e_seld;
    e_drdy = e_mval && memreq_rdy && e_seld;
    e_ival = memresp_val && (m_owner.size() > 0) && (m_owner[0] == 1'b0);
    e_dval = memresp_val && (m_owner.size() > 0) && (m_owner[0] == 1'b1);
    e_type  = e_seld ? dmemreq_type  : 1'b0;
    e_addr  = e_seld ? dmemreq_addr  : imemreq_addr;
    e_wdata = e_seld ? dmemreq_wdata : 32'd0;
  endtask

  task automatic model_commit();
    if (e_ival || e_dval) void'(m_owner.pop_front());
    if (e_irdy || e_drdy) begin
      m_owner.push_back(e_seld);
      if (imemreq_val && dmemreq_val) m_fav = !e_seld;
    end
    if (e_irdy) m_pi++;
    if (e_drdy) m_pd++;
    if (imemreq_val && dmemreq_val) m_pc++;
  endtask

  task automatic step();
    model_eval();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imemreq_val = 0; imemreq_addr = 0;
    dmemreq_val = 0; dmemreq_type = 0; dmemreq_addr = 0; dmemreq_wdata = 0;
    memreq_rdy = 0; memresp_val = 0; memresp_data = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imemreq_val = 1; dmemreq_val = 1; memreq_rdy = 1; memresp_val = 1;
    #2;
    tests_run++;
    if ({memreq_val, imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val} !== 5'b0) begin
      failures++;
      $display("FAIL reset_handshake: got %b want 00000",
               {memreq_val, imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val});
    end
    tests_run++;
    if ({perf_imem_grants, perf_dmem_grants, perf_conflicts} !== 96'd0) begin
      failures++;
      $display("FAIL reset_perf: got %h %h %h want 0", perf_imem_grants, perf_dmem_grants, perf_conflicts);
    end
    do_reset();
  endtask

  task automatic test_imem_stream();
    logic [31:0] addrs [3];
    logic [31:0] rdat  [3];
    addrs = '{32'h0, 32'h4, 32'h8};
    rdat  = '{32'h11, 32'h22, 32'h33};
    do_reset();
    memreq_rdy = 1;
    for (int k = 0; k < 5; k++) begin
      imemreq_val = (k < 3);
      if (k < 3) imemreq_addr = addrs[k];
      memresp_val = (k >= 2);
      if (k >= 2) memresp_data = rdat[k-2];
      @(negedge clk);
      if (k < 3) begin
        tests_run++;
        if ({imemreq_rdy, memreq_val, memreq_type} !== 3'b110 || memreq_addr !== addrs[k] || memreq_wdata !== 32'd0) begin
          failures++;
          $display("FAIL imem_req[%0d]: got rdy/val/type %b addr %h wdata %h want 110 addr %h wdata 0",
                   k, {imemreq_rdy, memreq_val, memreq_type}, memreq_addr, memreq_wdata, addrs[k]);
        end
      end
      if (k >= 2) begin
        tests_run++;
        if (imemresp_val !== 1'b1 || imemresp_data !== rdat[k-2]) begin
          failures++;
          $display("FAIL imem_resp[%0d]: got val %b data %h want 1 %h", k, imemresp_val, imemresp_data, rdat[k-2]);
        end
      end
      tests_run++;
      if ({dmemresp_val, dmemreq_rdy} !== 2'b00) begin
        failures++;
        $display("FAIL imem_stream_dmem_quiet[%0d]: got %b want 00", k, {dmemresp_val, dmemreq_rdy});
      end
      step();
    end
    imemreq_val = 0; memresp_val = 0;
  endtask

  task automatic test_conflict();
    int ni, nd;
    logic want_d;
    logic [31:0] want_a;
    ni = 0; nd = 0;
    do_reset();
    memreq_rdy = 1; dmemreq_type = 0;
    for (int k = 0; k < 4; k++) begin
      imemreq_val = 1; dmemreq_val = 1;
      imemreq_addr = 32'h1000 + ni;
      dmemreq_addr = 32'h2000 + nd;
      want_d = (k % 2 == 1);
      want_a = want_d ? 32'h2000 + (k / 2) : 32'h1000 + (k / 2);
      @(negedge clk);
      tests_run++;
      if ({imemreq_rdy, dmemreq_rdy} !== {!want_d, want_d} || memreq_addr !== want_a) begin
        failures++;
        $display("FAIL conflict_grant[%0d]: got rdy %b addr %h want %b addr %h",
                 k, {imemreq_rdy, dmemreq_rdy}, memreq_addr, {!want_d, want_d}, want_a);
      end
      step();
      if (want_d) nd++; else ni++;
    end
    imemreq_val = 0; dmemreq_val = 0;
    for (int k = 0; k < 4; k++) begin
      memresp_val = 1; memresp_data = 32'hA0 + k;
      want_d = (k % 2 == 1);
      @(negedge clk);
      tests_run++;
      if ({imemresp_val, dmemresp_val} !== {!want_d, want_d} ||
          imemresp_data !== 32'hA0 + k || dmemresp_data !== 32'hA0 + k) begin
        failures++;
        $display("FAIL conflict_route[%0d]: got val %b data %h/%h want %b data %h",
                 k, {imemresp_val, dmemresp_val}, imemresp_data, dmemresp_data, {!want_d, want_d}, 32'hA0 + k);
      end
      step();
    end
    memresp_val = 0;
  endtask

  task automatic test_full();
    do_reset();
    memreq_rdy = 1; imemreq_val = 1; imemreq_addr = 32'h40;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (imemreq_rdy !== 1'b1) begin
        failures++;
        $display("FAIL full_fill[%0d]: got rdy %b want 1", k, imemreq_rdy);
      end
      step();
    end
    @(negedge clk);
    tests_run++;
    if ({imemreq_rdy, memreq_val} !== 2'b00) begin
      failures++;
      $display("FAIL full_block: got rdy/val %b want 00", {imemreq_rdy, memreq_val});
    end
    step();
    memresp_val = 1; memresp_data = 32'h77;
    @(negedge clk);
    tests_run++;
    if ({imemresp_val, imemreq_rdy} !== 2'b10) begin
      failures++;
      $display("FAIL full_no_bypass: got resp/rdy %b want 10", {imemresp_val, imemreq_rdy});
    end
    step();
    memresp_val = 0;
    @(negedge clk);
    tests_run++;
    if (imemreq_rdy !== 1'b1) begin
      failures++;
      $display("FAIL full_release: got rdy %b want 1", imemreq_rdy);
    end
    step();
    imemreq_val = 0;
  endtask

  task automatic test_stall();
    do_reset();
    dmemreq_val = 1; dmemreq_type = 1; dmemreq_addr = 32'h100; dmemreq_wdata = 32'hDEADBEEF;
    memreq_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) memreq_rdy = 1;
      @(negedge clk);
      tests_run++;
      if ({memreq_val, memreq_type, dmemreq_rdy} !== {2'b11, (k == 2)} ||
          memreq_addr !== 32'h100 || memreq_wdata !== 32'hDEADBEEF) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got val/type/rdy %b addr %h wdata %h want %b 100 deadbeef",
                 k, {memreq_val, memreq_type, dmemreq_rdy}, memreq_addr, memreq_wdata, {2'b11, (k == 2)});
      end
      step();
    end
    dmemreq_val = 0;
    @(negedge clk);
    tests_run++;
    if (memreq_val !== 1'b0) begin
      failures++;
      $display("FAIL stall_single_fire: got val %b want 0", memreq_val);
    end
    step();
    for (int k = 0; k < 2; k++) begin
      memresp_val = 1; memresp_data = 32'h5;
      @(negedge clk);
      tests_run++;
      if ({imemresp_val, dmemresp_val} !== ((k == 0) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL stall_resp[%0d]: got %b want %b", k, {imemresp_val, dmemresp_val}, (k == 0) ? 2'b01 : 2'b00);
      end
      step();
    end
    memresp_val = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    memreq_rdy = 1; imemreq_val = 1; imemreq_addr = 32'h200;
    step();
    step();
    #1 rst = 1'b1;
    memresp_val = 1;
    #1;
    tests_run++;
    if ({memreq_val, imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val} !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %b want 00000",
               {memreq_val, imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val});
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0; imemreq_val = 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      memresp_val = 1; memresp_data = 32'h99;
      @(negedge clk);
      tests_run++;
      if ({imemresp_val, dmemresp_val} !== 2'b00) begin
        failures++;
        $display("FAIL reset_mid_drop[%0d]: got %b want 00", k, {imemresp_val, dmemresp_val});
      end
      step();
    end
    memresp_val = 0;
  endtask

  task automatic test_perf();
    logic [31:0] wi, wd, wc;
    do_reset();
    memreq_rdy = 1;
    for (int k = 0; k < 7; k++) begin
      imemreq_val = 1; dmemreq_val = (k < 5);
      imemreq_addr = 32'h300 + k; dmemreq_addr = 32'h400 + k;
      memresp_val = (k > 0);
      step();
    end
    imemreq_val = 0; dmemreq_val = 0; memresp_val = 0;
`ifdef MEM_ARB_PERF_EN
    wi = 5; wd = 2; wc = 5;
`else
    wi = 0; wd = 0; wc = 0;
`endif
    @(negedge clk);
    tests_run++;
    if (perf_conflicts !== wc || perf_imem_grants !== wi || perf_dmem_grants !== wd) begin
      failures++;
      $display("FAIL perf_counts: got c/i/d %0d/%0d/%0d want %0d/%0d/%0d",
               perf_conflicts, perf_imem_grants, perf_dmem_grants, wc, wi, wd);
    end
    step();
  endtask

  task automatic test_random();
    logic last_irdy, last_drdy;
    logic [31:0] wi, wd, wc;
    last_irdy = 0; last_drdy = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (!imemreq_val || last_irdy) begin
        imemreq_val  = 1'($urandom_range(0, 1));
        imemreq_addr = $urandom;
      end
      if (!dmemreq_val || last_drdy) begin
        dmemreq_val   = 1'($urandom_range(0, 1));
        dmemreq_type  = 1'($urandom_range(0, 1));
        dmemreq_addr  = $urandom;
        dmemreq_wdata = $urandom;
      end
      memreq_rdy   = ($urandom_range(0, 3) != 0);
      memresp_val  = (m_owner.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
      memresp_data = $urandom;
      @(negedge clk);
      model_eval();
      tests_run++;
      if ({memreq_val, imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val} !==
          {e_mval, e_irdy, e_drdy, e_ival, e_dval}) begin
        failures++;
        $display("FAIL rand_ctrl[%0d]: got %b want %b", n,
                 {memreq_val, imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val},
                 {e_mval, e_irdy, e_drdy, e_ival, e_dval});
      end
      if (e_mval) begin
        tests_run++;
        if (memreq_type !== e_type || memreq_addr !== e_addr || memreq_wdata !== e_wdata) begin
          failures++;
          $display("FAIL rand_fields[%0d]: got %b %h %h want %b %h %h", n,
                   memreq_type, memreq_addr, memreq_wdata, e_type, e_addr, e_wdata);
        end
      end
      if (e_ival || e_dval) begin
        tests_run++;
        if (imemresp_data !== memresp_data || dmemresp_data !== memresp_data) begin
          failures++;
          $display("FAIL rand_rdata[%0d]: got %h/%h want %h", n, imemresp_data, dmemresp_data, memresp_data);
        end
      end
      last_irdy = e_irdy; last_drdy = e_drdy;
      step();
    end
    imemreq_val = 0; dmemreq_val = 0; memresp_val = 0;
`ifdef MEM_ARB_PERF_EN
    wi = m_pi; wd = m_pd; wc = m_pc;
`else
    wi = 0; wd = 0; wc = 0;
`endif
    @(negedge clk);
    tests_run++;
    if (perf_conflicts !== wc || perf_imem_grants !== wi || perf_dmem_grants !== wd) begin
      failures++;
      $display("FAIL rand_perf: got c/i/d %0d/%0d/%0d want %0d/%0d/%0d",
               perf_conflicts, perf_imem_grants, perf_dmem_grants, wc, wi, wd);
    end
    step();
  endtask

  initial begin
    rst = 1'b1;
    imemreq_val = 0; imemreq_addr = 0;
    dmemreq_val = 0; dmemreq_type = 0; dmemreq_addr = 0; dmemreq_wdata = 0;
    memreq_rdy = 0; memresp_val = 0; memresp_data = 0;
    model_clear();
    test_reset();
    test_imem_stream();
    test_conflict();
    test_full();
    test_stall();
    test_reset_mid();
    test_perf();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
`default_nettype wire
